// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters.
// One operation is accepted per cycle; the tagged result sits in a valid/ready output register.
module adder_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_op1,
  input  logic [NREQ*WIDTH-1:0] i_op2,
  output logic [NREQ-1:0]       o_ack,
  output logic                  o_valid,
  input  logic                  i_rdy,
  output logic [WIDTH-1:0]      o_out,
  output logic                  o_carry,
  output logic [IDW-1:0]        o_id
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [IDW-1:0]   win_c;
  logic [IDW-1:0]   cand_c;
  logic             found_c;
  logic             accept_c;
  logic [WIDTH-1:0] op1_c, op2_c;
  logic [WIDTH:0]   sum_c;

  // Winner: first requesting index scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    win_c   = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand_c = IDW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && i_req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // Accept while the output slot is free or being drained on this edge; never in reset.
  assign accept_c = ~i_rst & (~valid_q | i_rdy) & found_c;
  assign o_ack    = accept_c ? (NREQ'(1) << win_c) : '0;

  assign op1_c = i_op1[32'(win_c)*WIDTH +: WIDTH];
  assign op2_c = i_op2[32'(win_c)*WIDTH +: WIDTH];
  assign sum_c = {1'b0, op1_c} + {1'b0, op2_c};

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    carry_d = carry_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (accept_c) begin
      valid_d = 1'b1;
      out_d   = sum_c[WIDTH-1:0];
      carry_d = sum_c[WIDTH];
      id_d    = win_c;
      ptr_d   = (win_c == IDW'(NREQ - 1)) ? '0 : win_c + IDW'(1);
    end else if (valid_q && i_rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_out   = out_q;
  assign o_carry = carry_q;
  assign o_id    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed table-driven bench for adder_rr_arbiter (NREQ=4, WIDTH=32).
// Fixed per-requester operands; expected sums are computed by hand below.
module tb_adder_rr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 2;

  // k0: 0x10+0x05=0x15 c0 | k1: FFFFFFFF+1=0 c1 | k2: 0x102+0x20=0x122 c0 | k3: 80000003+80000001=4 c1
  localparam logic [NREQ*WIDTH-1:0] OP1 = {32'h8000_0003, 32'h0000_0102, 32'hFFFF_FFFF, 32'h0000_0010};
  localparam logic [NREQ*WIDTH-1:0] OP2 = {32'h8000_0001, 32'h0000_0020, 32'h0000_0001, 32'h0000_0005};

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op1, op2;
  logic [NREQ-1:0]       ack;
  logic                  valid;
  logic                  rdy;
  logic [WIDTH-1:0]      sum;
  logic                  carry;
  logic [IDW-1:0]        id;

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_op1  (op1),
    .i_op2  (op2),
    .o_ack  (ack),
    .o_valid(valid),
    .i_rdy  (rdy),
    .o_out  (sum),
    .o_carry(carry),
    .o_id   (id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]  req;
    logic             rdy;
    logic [NREQ-1:0]  exp_ack;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_out;
    logic             exp_carry;
    logic [IDW-1:0]   exp_id;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic v, input logic [WIDTH-1:0] o,
                          input logic c, input logic [IDW-1:0] i);
    chk({tag, ".valid"}, 64'(valid), 64'(v));
    chk({tag, ".out"},   64'(sum),   64'(o));
    chk({tag, ".carry"}, 64'(carry), 64'(c));
    chk({tag, ".id"},    64'(id),    64'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // req, rdy, ack, then registered state after the edge
    vecs[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 32'h0000_0000, 1'b1, 2'd1}; // carry wrap, ptr->2
    vecs[1]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'h0000_0122, 1'b0, 2'd2};
    vecs[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'h0000_0004, 1'b1, 2'd3};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'h0000_0015, 1'b0, 2'd0};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'h0000_0000, 1'b1, 2'd1}; // ptr->2
    vecs[5]  = '{4'b1011, 1'b1, 4'b1000, 1'b1, 32'h0000_0004, 1'b1, 2'd3}; // skip idle 2
    vecs[6]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 32'h0000_0015, 1'b0, 2'd0};
    vecs[7]  = '{4'b1011, 1'b1, 4'b0010, 1'b1, 32'h0000_0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b1011, 1'b1, 4'b1000, 1'b1, 32'h0000_0004, 1'b1, 2'd3}; // ptr->0
    vecs[9]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'h0000_0004, 1'b1, 2'd3}; // stall x3
    vecs[10] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'h0000_0004, 1'b1, 2'd3};
    vecs[11] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 32'h0000_0004, 1'b1, 2'd3};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'h0000_0122, 1'b0, 2'd2}; // ptr->3
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0000_0122, 1'b0, 2'd2}; // drain
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0000_0122, 1'b0, 2'd2}; // idle, ptr stays 3
    vecs[15] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 32'h0000_0015, 1'b0, 2'd0}; // empty slot ignores rdy
    vecs[16] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 32'h0000_0015, 1'b0, 2'd0}; // stall
    vecs[17] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'h0000_0004, 1'b1, 2'd3}; // ptr->0
    vecs[18] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'h0000_0122, 1'b0, 2'd2}; // ptr->3

    rst = 1'b1;
    req = '0;
    rdy = 1'b0;
    op1 = OP1;
    op2 = OP2;

    repeat (2) @(negedge clk);
    req = 4'b1111;
    rdy = 1'b1;
    #1;
    chk("reset.ack", 64'(ack), 64'(0));
    chk_regs("reset", 1'b0, 32'h0, 1'b0, 2'd0);

    @(negedge clk);
    rst = 1'b0;
    req = '0;

    for (int v = 0; v < NVEC; v++) begin
      req = vecs[v].req;
      rdy = vecs[v].rdy;
      #1;
      chk($sformatf("v%0d.ack", v), 64'(ack), 64'(vecs[v].exp_ack));
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", v), vecs[v].exp_valid, vecs[v].exp_out,
               vecs[v].exp_carry, vecs[v].exp_id);
      @(negedge clk);
    end

    // Asynchronous reset mid-stream with a result pending and ptr=3.
    req = 4'b1001;
    rdy = 1'b1;
    #1;
    chk("pre_rst.ack", 64'(ack), 64'(4'b1000));
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.ack", 64'(ack), 64'(0));
    chk_regs("async_rst", 1'b0, 32'h0, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    chk("rst_hold.valid", 64'(valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.ack", 64'(ack), 64'(4'b0001));
    @(posedge clk);
    #1;
    chk_regs("post_rst", 1'b1, 32'h0000_0015, 1'b0, 2'd0);

    // Operands changed per operation: only the acked slice feeds the adder.
    @(negedge clk);
    op1 = {32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_0000};
    op2 = {32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 32'h0000_BEEF};
    req = 4'b0011;
    rdy = 1'b1;
    #1;
    chk("ops.ack", 64'(ack), 64'(4'b0010));
    @(posedge clk);
    #1;
    chk_regs("ops", 1'b1, 32'h2345_6789, 1'b0, 2'd1);

    @(negedge clk);
    req = '0;
    #1;
    chk("final.ack", 64'(ack), 64'(0));
    @(posedge clk);
    #1;
    chk_regs("final", 1'b0, 32'h2345_6789, 1'b0, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
